// File: rtl/cpu_sram_responder.sv
// rtl/cpu_sram_responder.sv - serialises CPU fetch and load/store requests onto one SRAM-like bus
// Optional: CPU_SRAM_ADDR_MAP_EN enables the fixed kseg0/kseg1 physical address mapping.
module cpu_sram_responder #(
    parameter int DATA_FIRST      = 1,
    parameter int WATCHDOG_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_en,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        stallreq_from_if,
    input  logic        data_en,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_sel,
    input  logic [1:0]  data_size,
    output logic [31:0] data_rdata,
    output logic        stallreq_from_mem,
    input  logic        flush,
    input  logic        cpu_longest_stall,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    typedef enum logic [2:0] {IDLE, D_ADDR, D_WAIT, I_ADDR, I_WAIT} state_t;

    state_t      state_q, state_d;
    logic        inst_done_q, inst_done_d;
    logic        data_done_q, data_done_d;
    logic [31:0] inst_hold_q, inst_hold_d;
    logic [31:0] data_hold_q, data_hold_d;
    logic        discard_q, discard_d;
    logic        is_store_q, is_store_d;
    logic [31:0] wdog_cnt_q, wdog_cnt_d;
    logic        bus_err_q, bus_err_d;
    logic        pend_data, pend_inst;

    function automatic logic [31:0] map_addr(input logic [31:0] va);
`ifdef CPU_SRAM_ADDR_MAP_EN
        if (va[31:30] == 2'b10) begin
            return {3'b000, va[28:0]};
        end
        return va;
`else
        return va;
`endif
    endfunction

    assign stallreq_from_if  = inst_en & ~inst_done_q;
    assign stallreq_from_mem = data_en & ~data_done_q;
    assign inst_rdata        = inst_hold_q;
    assign data_rdata        = data_hold_q;
    assign bus_err           = bus_err_q;

    always_comb begin
        pend_data   = data_en & ~data_done_q & ~flush;
        pend_inst   = inst_en & ~inst_done_q & ~flush;
        state_d     = state_q;
        inst_hold_d = inst_hold_q;
        data_hold_d = data_hold_q;
        discard_d   = discard_q;
        is_store_d  = is_store_q;
        wdog_cnt_d  = '0;
        bus_err_d   = bus_err_q;
        bus_req     = 1'b0;
        bus_wr      = 1'b0;
        bus_size    = 2'd0;
        bus_addr    = '0;
        bus_wstrb   = 4'd0;
        bus_wdata   = '0;
        inst_done_d = inst_done_q;
        data_done_d = data_done_q;
        // Completed results are only held while the pipeline is frozen.
        if (!cpu_longest_stall || flush) begin
            inst_done_d = 1'b0;
            data_done_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pend_data && (DATA_FIRST != 0 || !pend_inst)) begin
                    state_d = D_ADDR;
                end else if (pend_inst) begin
                    state_d = I_ADDR;
                end
            end
            D_ADDR: begin
                bus_req   = 1'b1;
                bus_wr    = data_we;
                bus_size  = data_size;
                bus_addr  = map_addr(data_addr);
                bus_wstrb = data_we ? data_sel : 4'd0;
                bus_wdata = data_wdata;
                if (bus_addr_ok) begin
                    state_d    = D_WAIT;
                    is_store_d = data_we;
                    discard_d  = flush;
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            I_ADDR: begin
                bus_req  = 1'b1;
                bus_size = 2'd2;
                bus_addr = map_addr(inst_addr);
                if (bus_addr_ok) begin
                    state_d   = I_WAIT;
                    discard_d = flush;
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            D_WAIT, I_WAIT: begin
                if (flush) begin
                    discard_d = 1'b1;
                end
                if (bus_data_ok) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                    // A flushed transaction still drains the bus but must not satisfy a new request.
                    if (!discard_q && !flush) begin
                        if (state_q == D_WAIT) begin
                            data_done_d = 1'b1;
                            if (!is_store_q) begin
                                data_hold_d = bus_rdata;
                            end
                        end else begin
                            inst_done_d = 1'b1;
                            inst_hold_d = bus_rdata;
                        end
                    end
                end else begin
                    wdog_cnt_d = (wdog_cnt_q == '1) ? wdog_cnt_q : wdog_cnt_q + 32'd1;
                    if (WATCHDOG_CYCLES != 0 && wdog_cnt_d == 32'(WATCHDOG_CYCLES)) begin
                        bus_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            inst_done_q <= 1'b0;
            data_done_q <= 1'b0;
            inst_hold_q <= '0;
            data_hold_q <= '0;
            discard_q   <= 1'b0;
            is_store_q  <= 1'b0;
            wdog_cnt_q  <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            inst_done_q <= inst_done_d;
            data_done_q <= data_done_d;
            inst_hold_q <= inst_hold_d;
            data_hold_q <= data_hold_d;
            discard_q   <= discard_d;
            is_store_q  <= is_store_d;
            wdog_cnt_q  <= wdog_cnt_d;
            bus_err_q   <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_cpu_sram_responder.sv
// tb/tb_cpu_sram_responder.sv - self-checking bench for cpu_sram_responder
module tb_cpu_sram_responder;

    logic        clk, rst;
    logic        inst_en, data_en, data_we, flush, cpu_longest_stall;
    logic [31:0] inst_addr, data_addr, data_wdata, bus_rdata;
    logic [3:0]  data_sel;
    logic [1:0]  data_size;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] inst_rdata, data_rdata, bus_addr, bus_wdata;
    logic        stallreq_from_if, stallreq_from_mem, bus_req, bus_wr, bus_err;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;

    cpu_sram_responder #(.DATA_FIRST(1), .WATCHDOG_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .stallreq_from_if(stallreq_from_if),
        .data_en(data_en), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_sel(data_sel), .data_size(data_size),
        .data_rdata(data_rdata), .stallreq_from_mem(stallreq_from_mem),
        .flush(flush), .cpu_longest_stall(cpu_longest_stall),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_inst, exp_data;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  exp_wstrb;
    } dvec_t;

    typedef struct {
        logic        is_inst;
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } req_t;

    dvec_t tbl[4];
    req_t  q[$];
    req_t  cur;
    req_t  rr;

    function automatic logic [31:0] vmap(input logic [31:0] va);
`ifdef CPU_SRAM_ADDR_MAP_EN
        if (va[31:29] == 3'b100 || va[31:29] == 3'b101) return {3'b000, va[28:0]};
`endif
        return va;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; inst_en = 0; data_en = 0; data_we = 0; flush = 0; cpu_longest_stall = 0;
        inst_addr = 0; data_addr = 0; data_wdata = 0; data_sel = 0; data_size = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
        exp_inst = 0; exp_data = 0;
        tick(); tick();
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_inst_rdata", inst_rdata, 0);
        chk("rst_data_rdata", data_rdata, 0);
        chk("rst_stalls", {stallreq_from_if, stallreq_from_mem}, 0);
        chk("rst_bus_err", bus_err, 0);
        rst = 1'b0;
        tick();

        // Zero-wait fetch: stall high for exactly three cycles.
        inst_en = 1; inst_addr = 32'hBFC0_0000; cpu_longest_stall = 1;
        #1;
        chk("zw_stall_c0", stallreq_from_if, 1);
        chk("zw_req_c0", bus_req, 0);
        tick();
        chk("zw_req_c1", bus_req, 1);
        chk("zw_addr", bus_addr, vmap(32'hBFC0_0000));
        chk("zw_ctl", {bus_wr, bus_size, bus_wstrb}, {1'b0, 2'd2, 4'd0});
        chk("zw_stall_c1", stallreq_from_if, 1);
        bus_addr_ok = 1;
        tick();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h3C08_BFC0;
        #1;
        chk("zw_req_c2", bus_req, 0);
        chk("zw_stall_c2", stallreq_from_if, 1);
        tick();
        bus_data_ok = 0;
        exp_inst = 32'h3C08_BFC0;
        chk("zw_stall_c3", stallreq_from_if, 0);
        chk("zw_inst_rdata", inst_rdata, exp_inst);
        inst_en = 0; cpu_longest_stall = 0;
        tick();

        // Table-driven data accesses with a zero-wait slave.
        tbl[0] = '{1'b0, 4'hF,    2'd2, 32'h8000_1000, 32'h0000_0000, 32'h1234_5678, 4'h0};
        tbl[1] = '{1'b1, 4'b0100, 2'd0, 32'h8000_0002, 32'h00AB_0000, 32'hFFFF_FFFF, 4'b0100};
        tbl[2] = '{1'b1, 4'b1100, 2'd1, 32'h0040_0012, 32'h5566_0000, 32'h0101_0101, 4'b1100};
        tbl[3] = '{1'b0, 4'b0010, 2'd0, 32'hA000_0001, 32'h0000_0000, 32'h0000_9A00, 4'h0};
        for (int i = 0; i < 4; i++) begin
            data_en = 1; data_we = tbl[i].we; data_sel = tbl[i].sel; data_size = tbl[i].size;
            data_addr = tbl[i].addr; data_wdata = tbl[i].wdata; cpu_longest_stall = 1;
            tick();
            chk("tbl_req", bus_req, 1);
            chk("tbl_addr", bus_addr, vmap(tbl[i].addr));
            chk("tbl_ctl", {bus_wr, bus_size, bus_wstrb}, {tbl[i].we, tbl[i].size, tbl[i].exp_wstrb});
            chk("tbl_wdata", bus_wdata, tbl[i].wdata);
            bus_addr_ok = 1;
            tick();
            bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = tbl[i].rdata;
            tick();
            bus_data_ok = 0;
            if (!tbl[i].we) exp_data = tbl[i].rdata;
            chk("tbl_stall", stallreq_from_mem, 0);
            chk("tbl_rdata", data_rdata, exp_data);
            data_en = 0; cpu_longest_stall = 0;
            tick();
        end

        // Concurrent fetch and load: data served first.
        inst_en = 1; inst_addr = 32'h8000_0200;
        data_en = 1; data_we = 0; data_addr = 32'h8000_1000; data_size = 2; data_sel = 4'hF;
        cpu_longest_stall = 1;
        tick();
        chk("cc_first_addr", bus_addr, vmap(32'h8000_1000));
        bus_addr_ok = 1;
        tick();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h1234_5678;
        tick();
        bus_data_ok = 0; exp_data = 32'h1234_5678;
        chk("cc_mem_first", {stallreq_from_mem, stallreq_from_if}, 2'b01);
        chk("cc_data_rdata", data_rdata, exp_data);
        tick();
        chk("cc_second_req", bus_req, 1);
        chk("cc_second_addr", bus_addr, vmap(32'h8000_0200));
        bus_addr_ok = 1;
        tick();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h2402_0001;
        tick();
        bus_data_ok = 0; exp_inst = 32'h2402_0001;
        chk("cc_if_done", stallreq_from_if, 0);
        chk("cc_inst_rdata", inst_rdata, exp_inst);
        cpu_longest_stall = 0;
        tick();
        chk("cc_done_cleared", {stallreq_from_if, stallreq_from_mem}, 2'b11);
        inst_en = 0; data_en = 0;
        tick();
        chk("cc_idle", bus_req, 0);

        // Flush while the address phase is still waiting.
        data_en = 1; data_we = 0; data_addr = 32'h8000_2000; cpu_longest_stall = 1;
        tick();
        chk("fa_req", bus_req, 1);
        flush = 1;
        tick();
        flush = 0; data_en = 0;
        #1;
        chk("fa_req_dropped", bus_req, 0);
        tick();
        chk("fa_still_idle", bus_req, 0);
        chk("fa_rdata", data_rdata, exp_data);
        cpu_longest_stall = 0;
        tick();

        // Flush while waiting for data: result discarded.
        data_en = 1; data_we = 0; data_addr = 32'h8000_3000; cpu_longest_stall = 1;
        tick();
        bus_addr_ok = 1;
        tick();
        bus_addr_ok = 0; flush = 1;
        tick();
        flush = 0; bus_data_ok = 1; bus_rdata = 32'hDEAD_BEEF;
        tick();
        bus_data_ok = 0;
        chk("fw_rdata_kept", data_rdata, exp_data);
        chk("fw_not_done", stallreq_from_mem, 1);
        data_en = 0; cpu_longest_stall = 0;
        tick();
        chk("fw_idle", bus_req, 0);

        // Randomized transactions against a transaction-level model.
        for (int it = 0; it < 40; it++) begin
            int kind, cyc, wcnt, mem_drop, if_drop, served, nexp;
            logic outstanding;
            kind = int'($urandom_range(1, 3));
            q.delete();
            inst_addr = $urandom & 32'hFFFF_FFFC;
            data_size = 2'($urandom_range(0, 2));
            data_addr = $urandom;
            if (data_size == 2) data_addr[1:0] = 2'b00;
            if (data_size == 1) data_addr[0] = 1'b0;
            data_sel = (data_size == 2) ? 4'hF :
                       (data_size == 1) ? (4'b0011 << data_addr[1:0]) : (4'b0001 << data_addr[1:0]);
            data_we = 1'($urandom_range(0, 1));
            data_wdata = $urandom;
            if (kind != 1) begin
                rr = '{1'b0, vmap(data_addr), data_we, data_size, data_we ? data_sel : 4'h0,
                       data_wdata, $urandom};
                q.push_back(rr);
            end
            if (kind != 2) begin
                rr = '{1'b1, vmap(inst_addr), 1'b0, 2'd2, 4'h0, 32'h0, $urandom};
                q.push_back(rr);
            end
            nexp = q.size();
            inst_en = (kind != 2); data_en = (kind != 1); cpu_longest_stall = 1;
            cyc = 0; wcnt = 0; mem_drop = -1; if_drop = -1; served = 0; outstanding = 0;
            #1;
            while ((stallreq_from_if || stallreq_from_mem) && cyc < 100) begin
                bus_addr_ok = 0; bus_data_ok = 0;
                #1;
                if (bus_req && !outstanding) begin
                    if ($urandom_range(0, 1) == 1) begin
                        if (q.size() == 0) begin
                            chk("rnd_extra_req", 1, 0);
                        end else begin
                            cur = q.pop_front();
                            chk("rnd_req_addr", bus_addr, cur.addr);
                            chk("rnd_req_ctl", {bus_wr, bus_size, bus_wstrb}, {cur.wr, cur.size, cur.wstrb});
                            if (cur.wr) chk("rnd_req_wdata", bus_wdata, cur.wdata);
                            outstanding = 1; wcnt = 0; served++;
                            bus_addr_ok = 1;
                        end
                    end
                end else if (outstanding) begin
                    if (wcnt == 3 || $urandom_range(0, 1) == 1) begin
                        bus_data_ok = 1; bus_rdata = cur.rdata; outstanding = 0;
                        if (cur.is_inst) exp_inst = cur.rdata;
                        else if (!cur.wr) exp_data = cur.rdata;
                    end else begin
                        wcnt++;
                    end
                end
                tick();
                cyc++;
                if (!stallreq_from_mem && mem_drop < 0) mem_drop = cyc;
                if (!stallreq_from_if && if_drop < 0) if_drop = cyc;
            end
            bus_addr_ok = 0; bus_data_ok = 0;
            chk("rnd_timeout", (cyc < 100), 1);
            chk("rnd_served", served, nexp);
            chk("rnd_inst_rdata", inst_rdata, exp_inst);
            chk("rnd_data_rdata", data_rdata, exp_data);
            chk("rnd_bus_err", bus_err, 0);
            if (kind == 3) chk("rnd_order", (mem_drop < if_drop), 1);
            inst_en = 0; data_en = 0; cpu_longest_stall = 0;
            tick();
            chk("rnd_idle", bus_req, 0);
        end

        // Watchdog: four silent WAIT cycles set a sticky error.
        rst = 1;
        tick();
        rst = 0; exp_data = 0; exp_inst = 0;
        data_en = 1; data_we = 0; data_addr = 32'h8000_4000; data_size = 2; data_sel = 4'hF;
        cpu_longest_stall = 1;
        tick();
        bus_addr_ok = 1;
        tick();
        bus_addr_ok = 0;
        repeat (3) tick();
        chk("wd_not_yet", bus_err, 0);
        tick();
        chk("wd_set", bus_err, 1);
        tick(); tick();
        chk("wd_still_waiting", stallreq_from_mem, 1);
        bus_data_ok = 1; bus_rdata = 32'h0BAD_F00D;
        tick();
        bus_data_ok = 0;
        chk("wd_sticky", bus_err, 1);
        chk("wd_late_data", data_rdata, 32'h0BAD_F00D);
        data_en = 0; cpu_longest_stall = 0;
        tick();
        chk("wd_sticky2", bus_err, 1);
        rst = 1;
        #1;
        chk("wd_rst_clears", bus_err, 0);
        chk("wd_rst_hold", data_rdata, 0);
        tick();
        rst = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
